// File: rtl/delay_line.sv
// Fixed-latency register chain: dout presents din exactly DELAY clocks later.
// DELAY = 0 collapses to a wire; every stage clears asynchronously on rst_n low.
module delay_line #(
  parameter int WIDTH = 8,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (WIDTH < 1 || DELAY < 0) begin : g_param_check
    $error("delay_line: WIDTH must be >= 1 and DELAY must be >= 0");
  end

  if (DELAY == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n};
    assign dout        = din;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_p [DELAY];

    // stage_p[0] captures din; each later stage takes its predecessor
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DELAY; i++) stage_p[i] <= '0;
      end else begin
        stage_p[0] <= din;
        for (int i = 1; i < DELAY; i++) stage_p[i] <= stage_p[i-1];
      end
    end

    assign dout = stage_p[DELAY-1];
  end

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: several parameterisations driven together,
// compared against a sample-history model of what each delay should emit.
module tb_delay_line;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  din8  = 8'h00;
  logic [71:0] din72 = '0;
  logic [7:0]  d0, d2, d3, d4, d16;
  logic [71:0] d72;

  int checks = 0;
  int errors = 0;

  // Every value sampled since the last reset, oldest first
  logic [7:0] hist [$];

  always #5 clk = ~clk;

  delay_line #(.WIDTH(8),  .DELAY(0))  u_d0  (.clk(clk), .rst_n(rst_n), .din(din8),  .dout(d0));
  delay_line #(.WIDTH(8),  .DELAY(2))  u_d2  (.clk(clk), .rst_n(rst_n), .din(din8),  .dout(d2));
  delay_line #(.WIDTH(8),  .DELAY(3))  u_d3  (.clk(clk), .rst_n(rst_n), .din(din8),  .dout(d3));
  delay_line #(.WIDTH(8),  .DELAY(4))  u_d4  (.clk(clk), .rst_n(rst_n), .din(din8),  .dout(d4));
  delay_line #(.WIDTH(8),  .DELAY(16)) u_d16 (.clk(clk), .rst_n(rst_n), .din(din8),  .dout(d16));
  delay_line #(.WIDTH(72), .DELAY(1))  u_d72 (.clk(clk), .rst_n(rst_n), .din(din72), .dout(d72));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist.delete();
    else begin
      hist.push_back(din8);
      if (hist.size() > 40) void'(hist.pop_front());
    end
  end

  // Output of a D-cycle delay: the D-th most recent sample, or 0 if fewer exist
  function automatic logic [7:0] exp8(int d);
    if (d == 0) return din8;
    if (hist.size() < d) return 8'h00;
    return hist[hist.size() - d];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din8  = 8'h00;
    din72 = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din8  = 8'h3C;
    #1;
    checks++; if (d2  !== 8'h00) begin errors++; $display("FAIL reset_d2 got=%h exp=00", d2); end
    checks++; if (d3  !== 8'h00) begin errors++; $display("FAIL reset_d3 got=%h exp=00", d3); end
    checks++; if (d4  !== 8'h00) begin errors++; $display("FAIL reset_d4 got=%h exp=00", d4); end
    checks++; if (d16 !== 8'h00) begin errors++; $display("FAIL reset_d16 got=%h exp=00", d16); end
    checks++; if (d72 !== 72'h0) begin errors++; $display("FAIL reset_d72 got=%h exp=0", d72); end
    checks++; if (d0  !== 8'h3C) begin errors++; $display("FAIL reset_d0 got=%h exp=3c", d0); end
  endtask

  task automatic test_latency();
    logic [7:0] e;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      din8 = 8'(k);
      step();
      e = (k >= 3) ? 8'(k - 2) : 8'h00;
      checks++;
      if (d3 !== e) begin errors++; $display("FAIL latency edge=%0d got=%h exp=%h", k, d3, e); end
    end
  endtask

  task automatic test_wire();
    for (int i = 0; i < 20; i++) begin
      din8 = 8'($urandom);
      if (i % 3 == 1) rst_n = ~rst_n;
      #1;
      checks++;
      if (d0 !== din8) begin errors++; $display("FAIL wire i=%0d got=%h exp=%h", i, d0, din8); end
      step();
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    rst_n = 1'b1;
    din8  = 8'hAA;
    repeat (6) step();
    checks++; if (d4 !== 8'hAA) begin errors++; $display("FAIL fill_d4 got=%h exp=aa", d4); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (d4  !== 8'h00) begin errors++; $display("FAIL async_d4 got=%h exp=00", d4); end
    checks++; if (d16 !== 8'h00) begin errors++; $display("FAIL async_d16 got=%h exp=00", d16); end
    checks++; if (d2  !== 8'h00) begin errors++; $display("FAIL async_d2 got=%h exp=00", d2); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (d4 !== 8'h00) begin errors++; $display("FAIL hold_d4 c=%0d got=%h exp=00", c, d4); end
    end
    rst_n = 1'b1;
    din8  = 8'h55;
    for (int k = 1; k <= 6; k++) begin
      step();
      e = (k >= 4) ? 8'h55 : 8'h00;
      checks++;
      if (d4 !== e) begin errors++; $display("FAIL release_d4 edge=%0d got=%h exp=%h", k, d4, e); end
    end
  endtask

  task automatic test_midstream();
    logic after;
    logic [7:0] e;
    after = 1'b0;
    do_reset();
    for (int v = 8'h10; v <= 8'h1F; v++) begin
      din8  = 8'(v);
      rst_n = (v != 8'h15);
      if (v == 8'h15) after = 1'b1;
      #1;
      if (!rst_n) begin
        checks++;
        if (d2 !== 8'h00) begin errors++; $display("FAIL mid_in_reset got=%h exp=00", d2); end
      end
      step();
      e = exp8(2);
      checks++;
      if (d2 !== e) begin errors++; $display("FAIL mid_stream v=%h got=%h exp=%h", v, d2, e); end
      if (after) begin
        checks++;
        if (d2 === 8'h13 || d2 === 8'h14) begin
          errors++; $display("FAIL mid_stale v=%h got=%h exp=not13or14", v, d2);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wide();
    logic [71:0] prev;
    do_reset();
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      din72 = (i % 2 == 0) ? {72{1'b1}} : 72'h0;
      #1;
      checks++;
      if (d72 !== prev) begin errors++; $display("FAIL wide_hold i=%0d got=%h exp=%h", i, d72, prev); end
      step();
      checks++;
      if (d72 !== din72) begin errors++; $display("FAIL wide_out i=%0d got=%h exp=%h", i, d72, din72); end
      prev = din72;
    end
  endtask

  task automatic test_long();
    int seen;
    int at;
    logic [7:0] e;
    seen = 0;
    at   = -1;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      din8 = (c == 2) ? 8'h5A : 8'h00;
      step();
      e = exp8(16);
      checks++;
      if (d16 !== e) begin errors++; $display("FAIL long c=%0d got=%h exp=%h", c, d16, e); end
      if (d16 !== 8'h00) begin seen++; at = c; end
    end
    checks++; if (seen != 1) begin errors++; $display("FAIL long_count got=%0d exp=1", seen); end
    checks++; if (at != 17)  begin errors++; $display("FAIL long_when got=%0d exp=17", at); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      din8  = 8'($urandom);
      rst_n = ($urandom_range(0, 15) != 0);
      step();
      checks++; if (d2  !== exp8(2))  begin errors++; $display("FAIL rand_d2 c=%0d got=%h exp=%h", c, d2, exp8(2)); end
      checks++; if (d3  !== exp8(3))  begin errors++; $display("FAIL rand_d3 c=%0d got=%h exp=%h", c, d3, exp8(3)); end
      checks++; if (d4  !== exp8(4))  begin errors++; $display("FAIL rand_d4 c=%0d got=%h exp=%h", c, d4, exp8(4)); end
      checks++; if (d16 !== exp8(16)) begin errors++; $display("FAIL rand_d16 c=%0d got=%h exp=%h", c, d16, exp8(16)); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wire();
    test_async_reset();
    test_midstream();
    test_wide();
    test_long();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
